rr_arbiter8: RTL

Round-robin arbiter that shares one resource among eight requesters and drives the resource's 3-bit select, which feeds the team's 3-to-8 one-hot decoder. The arbiter grants one requester at a time and holds the grant until that requester releases. An optional hold timeout forcibly revokes the grant, and the offending requester stays locked out until it drops its request. The block sits between the requesting masters and the shared decoded-select datapath.

---
 rtl/rr_arbiter8_if.sv | 25 ++
 rtl/rr_arbiter8.sv | 117 +++++++++++
 2 files changed

// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between the requesting masters and rr_arbiter8.
// The arbiter takes the slave modport; the requester side takes the master modport.
interface rr_arbiter8_if;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;
    logic       timeout;

    modport master (
        output req,
        input  gnt,
        input  sel,
        input  busy,
        input  timeout
    );

    modport slave (
        input  req,
        output gnt,
        output sel,
        output busy,
        output timeout
    );
endinterface

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with optional hold timeout and lockout of
// timed-out requesters; sel drives the shared 3-to-8 decoded-select datapath.
module rr_arbiter8 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input logic           clk,
    input logic           rst_n,
    rr_arbiter8_if.slave  bus
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    localparam bit         TO_EN     = (MAX_HOLD != 0);
    localparam logic [7:0] HOLD_LAST = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic [7:0] lock_q, lock_d;
    logic [7:0] gnt_q, gnt_d;
    logic [2:0] sel_q, sel_d;
    logic       busy_q, busy_d;
    logic       timeout_q, timeout_d;

    logic [7:0] elig;
    logic [2:0] idx;
    logic [2:0] win;
    logic       found;

    // Rotating priority search starting at ptr_q.
    always_comb begin
        elig  = bus.req & ~lock_q;
        idx   = '0;
        win   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            idx = ptr_q + 3'(i);
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        // A requester leaves lockout on any cycle its request is low.
        lock_d     = lock_q & bus.req;
        gnt_d      = gnt_q;
        sel_d      = sel_q;
        busy_d     = busy_q;
        timeout_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d    = BUSY;
                    sel_d      = win;
                    gnt_d      = 8'b1 << win;
                    busy_d     = 1'b1;
                    hold_cnt_d = '0;
                end
            end
            BUSY: begin
                if (!bus.req[sel_q]) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    ptr_d   = sel_q + 3'd1;
                end else if (TO_EN && hold_cnt_q == HOLD_LAST) begin
                    state_d        = IDLE;
                    gnt_d          = '0;
                    busy_d         = 1'b0;
                    timeout_d      = 1'b1;
                    lock_d[sel_q]  = 1'b1;
                    ptr_d          = sel_q + 3'd1;
                end else if (hold_cnt_q != 8'hFF) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            lock_q     <= '0;
            gnt_q      <= '0;
            sel_q      <= '0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            lock_q     <= lock_d;
            gnt_q      <= gnt_d;
            sel_q      <= sel_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.sel     = sel_q;
    assign bus.busy    = busy_q;
    assign bus.timeout = timeout_q;

endmodule
